// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions, mul/div op codes
// and the sequencer state encoding.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      MULDIV_MUL   = 2'b00,
      MULDIV_MULHU = 2'b01,
      MULDIV_DIVU  = 2'b10,
      MULDIV_REMU  = 2'b11
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU,
// issuing one ADD (shift-add) or SUB (restoring divide) per RUN cycle.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | ready for a request, ALU released
//   ST_RUN  | owns the ALU for WIDTH iterations
//   ST_DONE | result presented until rspReady handshake
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             reqValid,
   output logic             reqReady,
   input  logic [1:0]       reqOp,
   input  logic [WIDTH-1:0] reqA,
   input  logic [WIDTH-1:0] reqB,
   output logic             rspValid,
   input  logic             rspReady,
   output logic [WIDTH-1:0] rspResult,
   output logic             aluReq,
   output logic [WIDTH-1:0] aluSrcA,
   output logic [WIDTH-1:0] aluSrcB,
   output logic [3:0]       aluControl,
   input  logic [WIDTH-1:0] aluResult,
   input  logic [3:0]       aluFlags
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   muldiv_state_e    state_q, state_d;
   muldiv_op_e       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // hi: accumulator / partial remainder, lo: multiplier / quotient,
   // opb: multiplicand / divisor
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;

   logic             accept;
   logic             carry;
   logic [WIDTH-1:0] shifted;
   logic             unused_flags;

   assign carry        = aluFlags[FLAG_C];
   assign unused_flags = ^{aluFlags[FLAG_N], aluFlags[FLAG_Z], aluFlags[FLAG_V]};
   assign shifted      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
   assign accept       = (state_q == ST_IDLE) && reqValid && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (reqValid)            state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST)   state_d = ST_DONE;
            ST_DONE: if (rspReady)            state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      reqReady   = (state_q == ST_IDLE);
      aluReq     = 1'b0;
      aluSrcA    = '0;
      aluSrcB    = '0;
      aluControl = ALU_ADD;
      rspValid   = 1'b0;
      rspResult  = '0;
      if (state_q == ST_RUN) begin
         aluReq = 1'b1;
         if (is_div(op_q)) begin
            aluSrcA    = shifted;
            aluSrcB    = opb_q;
            aluControl = ALU_SUB;
         end else begin
            aluSrcA = hi_q;
            aluSrcB = lo_q[0] ? opb_q : '0;
         end
      end else if (state_q == ST_DONE) begin
         rspValid  = 1'b1;
         rspResult = (op_q == MULDIV_MUL || op_q == MULDIV_DIVU) ? lo_q : hi_q;
      end
   end

   always_comb begin
      op_d  = op_q;
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      opb_d = opb_q;
      if (accept) begin
         op_d  = muldiv_op_e'(reqOp);
         cnt_d = '0;
         hi_d  = '0;
         lo_d  = reqOp[1] ? reqA : reqB;
         opb_d = reqOp[1] ? reqB : reqA;
      end else if (state_q == ST_RUN) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (is_div(op_q)) begin
            hi_d = carry ? aluResult : shifted;
            lo_d = {lo_q[WIDTH-2:0], carry};
         end else begin
            hi_d = {carry, aluResult[WIDTH-1:1]};
            lo_d = {aluResult[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= MULDIV_MUL;
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         opb_q <= '0;
      end else begin
         op_q  <= op_d;
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         opb_q <= opb_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq with a parent-style ALU mux and a result scoreboard.
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             reqValid;
   logic             reqReady;
   logic [1:0]       reqOp;
   logic [WIDTH-1:0] reqA;
   logic [WIDTH-1:0] reqB;
   logic             rspValid;
   logic             rspReady;
   logic [WIDTH-1:0] rspResult;
   logic             aluReq;
   logic [WIDTH-1:0] aluSrcA;
   logic [WIDTH-1:0] aluSrcB;
   logic [3:0]       aluControl;
   logic [WIDTH-1:0] aluResult;
   logic [3:0]       aluFlags;

   logic [WIDTH-1:0] alu_a, alu_b;
   logic [3:0]       alu_ctl;
   logic             alu_c;

   int n_tests = 0;
   int n_fail  = 0;
   logic [WIDTH-1:0] exp_q[$];

   alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
      .reqA(reqA), .reqB(reqB),
      .rspValid(rspValid), .rspReady(rspReady), .rspResult(rspResult),
      .aluReq(aluReq), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .aluControl(aluControl), .aluResult(aluResult), .aluFlags(aluFlags)
   );

   // parent: the sequencer owns the ALU only while aluReq is high
   assign alu_a   = aluReq ? aluSrcA : 32'h0000_1111;
   assign alu_b   = aluReq ? aluSrcB : 32'h0000_2222;
   assign alu_ctl = aluReq ? aluControl : ALU_XOR;

   always_comb begin
      aluResult = '0;
      alu_c     = 1'b0;
      case (alu_ctl)
         ALU_ADD: {alu_c, aluResult} = {1'b0, alu_a} + {1'b0, alu_b};
         ALU_SUB: begin
            aluResult = alu_a - alu_b;
            alu_c     = (alu_a >= alu_b);
         end
         ALU_AND: aluResult = alu_a & alu_b;
         ALU_OR:  aluResult = alu_a | alu_b;
         default: aluResult = alu_a ^ alu_b;
      endcase
      aluFlags = {aluResult[WIDTH-1], (aluResult == '0), alu_c, 1'b0};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [63:0] p;
      p = {32'h0, a} * {32'h0, b};
      case (op)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic start_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input bit push);
      chk("req_ready_before", reqReady, 1);
      reqValid = 1'b1;
      reqOp    = op;
      reqA     = a;
      reqB     = b;
      @(posedge clk); #1;
      reqValid = 1'b0;
      if (push) exp_q.push_back(model(op, a, b));
   endtask

   task automatic wait_done();
      int e;
      int ones;
      e    = 0;
      ones = 0;
      while (!rspValid && e < 100) begin
         if (aluReq) ones++;
         @(posedge clk); #1;
         e++;
      end
      chk("latency_edges", 32'(e), 32'(WIDTH));
      chk("alureq_cycles", 32'(ones), 32'(WIDTH));
   endtask

   task automatic finish_op(input int hold);
      logic [WIDTH-1:0] first;
      logic [WIDTH-1:0] exp;
      first = rspResult;
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", rspValid, 1);
         chk("hold_stable", rspResult, first);
         chk("hold_req_ready", reqReady, 0);
         chk("hold_alu_req", aluReq, 0);
         @(posedge clk); #1;
      end
      rspReady = 1'b1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         exp = exp_q.pop_front();
         chk("result", rspResult, exp);
      end
      @(posedge clk); #1;
      rspReady = 1'b0;
      chk("post_valid", rspValid, 0);
      chk("post_req_ready", reqReady, 1);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int hold);
      start_op(op, a, b, 1'b1);
      wait_done();
      finish_op(hold);
   endtask

   initial begin
      int seen;
      rst_n    = 1'b0;
      flush    = 1'b0;
      reqValid = 1'b0;
      reqOp    = 2'b00;
      reqA     = '0;
      reqB     = '0;
      rspReady = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", reqReady, 1);
      chk("rst_rsp_valid", rspValid, 0);
      chk("rst_rsp_result", rspResult, 0);
      chk("rst_alu_req", aluReq, 0);
      chk("rst_src_a", aluSrcA, 0);
      chk("rst_src_b", aluSrcB, 0);
      chk("rst_alu_ctl", 32'(aluControl), 32'(ALU_ADD));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(2'b00, 32'd7, 32'd6, 0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(2'b10, 32'd100, 32'd7, 0);
      run_op(2'b11, 32'd100, 32'd7, 0);
      run_op(2'b10, 32'hFFFF_FFFF, 32'hC000_0000, 0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'hC000_0000, 0);
      run_op(2'b10, 32'h1234_5678, 32'h0, 0);
      run_op(2'b11, 32'h1234_5678, 32'h0, 5);
      run_op(2'b01, 32'h8000_0001, 32'h7FFF_FFFF, 2);

      for (int i = 0; i < 8; i++) begin
         run_op(2'(i % 4), $urandom, (i == 6) ? 32'(($urandom % 1000) + 1) : $urandom, 0);
      end

      // flush mid-RUN: nothing must come out
      start_op(2'b00, 32'd123, 32'd456, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      chk("flush_pre_alu_req", aluReq, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_alu_req", aluReq, 0);
      chk("flush_req_ready", reqReady, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (rspValid) seen++;
         @(posedge clk); #1;
      end
      chk("flush_no_rsp", 32'(seen), 0);

      // flush beats a simultaneous request
      reqValid = 1'b1;
      reqOp    = 2'b00;
      reqA     = 32'd3;
      reqB     = 32'd5;
      flush    = 1'b1;
      @(posedge clk); #1;
      reqValid = 1'b0;
      flush    = 1'b0;
      chk("flush_req_alu_req", aluReq, 0);
      chk("flush_req_ready", reqReady, 1);

      // flush in DONE together with rspReady
      start_op(2'b10, 32'd50, 32'd5, 1'b1);
      wait_done();
      flush    = 1'b1;
      rspReady = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      rspReady = 1'b0;
      void'(exp_q.pop_front());
      chk("flush_done_valid", rspValid, 0);
      chk("flush_done_ready", reqReady, 1);

      // async reset mid-RUN
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("arst_pre_alu_req", aluReq, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_alu_req", aluReq, 0);
      chk("arst_req_ready", reqReady, 1);
      chk("arst_rsp_valid", rspValid, 0);
      chk("arst_src_a", aluSrcA, 0);
      chk("arst_src_b", aluSrcB, 0);
      chk("arst_alu_ctl", 32'(aluControl), 32'(ALU_ADD));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(2'b00, 32'd7, 32'd6, 0);
      chk("sb_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
